// File: rtl/spi_shift_engine_if.sv
// ---------------------------------------------------------------------------
// spi_shift_engine_if
//
// Register-block side of the SPI shift engine. The register block drives the
// transfer request, the byte to send and the configuration fields. The engine
// returns the transfer-in-progress flag, the receive strobe and the received
// byte.
//
// Signals
//   send_data     transfer request level
//   mosi_data     byte to transmit
//   mstr          master enable
//   cpol          SCLK idle level
//   cpha          clock phase
//   lsbfe         1 = LSB first
//   spi_mode      00 run, 01 wait, 10 stop
//   sppr, spr     baud prescaler / rate selects
//   tip           transfer in progress
//   receive_data  one-cycle strobe, miso_data valid
//   miso_data     last received byte
//
// Modports
//   master  register block side (drives the request and configuration)
//   slave   shift engine side
// ---------------------------------------------------------------------------
interface spi_shift_engine_if;
    logic       send_data;
    logic [7:0] mosi_data;
    logic       mstr;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [1:0] spi_mode;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       tip;
    logic       receive_data;
    logic [7:0] miso_data;

    modport master (
        output send_data, mosi_data, mstr, cpol, cpha, lsbfe,
               spi_mode, sppr, spr,
        input  tip, receive_data, miso_data
    );

    modport slave (
        input  send_data, mosi_data, mstr, cpol, cpha, lsbfe,
               spi_mode, sppr, spr,
        output tip, receive_data, miso_data
    );
endinterface

// File: rtl/spi_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_shift_engine
//
// Transmit/receive stage of the SPI master. Generates SCLK, SS and MOSI from
// the register-block configuration, samples MISO and returns the received
// byte with a one-cycle strobe.
//
// Ports
//   PCLK      clock, rising edge
//   PRESETn   asynchronous active-low reset
//   bus       register-block side (spi_shift_engine_if.slave)
//   miso      serial input
//   sclk      serial clock
//   mosi      serial output
//   ss        slave select, active-low
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | ss high, sclk follows cpol, waits for a start request
//   ST_XFER | ss low, 16 SCLK edges spaced H PCLK cycles apart
//   ST_DONE | one cycle, ss high, receive_data pulse, miso_data updated
// ---------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int CNT_W = 11
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    spi_shift_engine_if.slave  bus,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               ss
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_lim_q;
    logic [4:0]       edge_q;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             cpol_q;
    logic             cpha_q;
    logic             lsbfe_q;
    logic             tip_q;
    logic             rd_q;
    logic [7:0]       miso_data_q;

    logic [CNT_W-1:0] half_lim_in;
    logic             start;
    logic             frozen;
    logic             tc;
    logic [4:0]       edge_nxt;
    logic             do_sample;
    logic             do_shift;
    logic [7:0]       rx_in;
    logic [7:0]       tx_next;
    logic             mosi_next;

    // Terminal count of the half-period counter is H-1, H = (sppr+1) << spr.
    always_comb begin
        half_lim_in = ((CNT_W'(bus.sppr) + CNT_W'(1)) << bus.spr) - CNT_W'(1);
    end

    always_comb begin
        start    = bus.send_data && bus.mstr && (bus.spi_mode != 2'b10);
        frozen   = (bus.spi_mode == 2'b10);
        tc       = (cnt_q == half_lim_q);
        edge_nxt = edge_q + 5'd1;

        // cpha=0: sample odd edges, shift even edges except the last.
        // cpha=1: shift odd edges from 3 on, sample even edges.
        if (cpha_q) begin
            do_sample = ~edge_nxt[0];
            do_shift  = edge_nxt[0] && (edge_nxt != 5'd1);
        end else begin
            do_sample = edge_nxt[0];
            do_shift  = ~edge_nxt[0] && (edge_nxt != 5'd16);
        end

        if (lsbfe_q) begin
            rx_in     = {miso, rx_sr[7:1]};
            tx_next   = {1'b0, tx_sr[7:1]};
            mosi_next = tx_sr[1];
        end else begin
            rx_in     = {rx_sr[6:0], miso};
            tx_next   = {tx_sr[6:0], 1'b0};
            mosi_next = tx_sr[6];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            cnt_q       <= '0;
            half_lim_q  <= '0;
            edge_q      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
            tip_q       <= 1'b0;
            rd_q        <= 1'b0;
            miso_data_q <= '0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            ss          <= 1'b1;
        end else begin
            rd_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk  <= bus.cpol;
                    ss    <= 1'b1;
                    tip_q <= 1'b0;
                    mosi  <= 1'b0;
                    if (start) begin
                        state      <= ST_XFER;
                        ss         <= 1'b0;
                        tip_q      <= 1'b1;
                        tx_sr      <= bus.mosi_data;
                        mosi       <= bus.lsbfe ? bus.mosi_data[0] : bus.mosi_data[7];
                        rx_sr      <= '0;
                        cpol_q     <= bus.cpol;
                        cpha_q     <= bus.cpha;
                        lsbfe_q    <= bus.lsbfe;
                        half_lim_q <= half_lim_in;
                        cnt_q      <= '0;
                        edge_q     <= '0;
                    end
                end

                ST_XFER: begin
                    if (!bus.mstr) begin
                        // Abort: drop the transfer without touching miso_data.
                        state <= ST_IDLE;
                        ss    <= 1'b1;
                        tip_q <= 1'b0;
                        mosi  <= 1'b0;
                        sclk  <= bus.cpol;
                    end else if (!frozen) begin
                        if (tc) begin
                            cnt_q  <= '0;
                            sclk   <= ~sclk;
                            edge_q <= edge_nxt;
                            if (do_sample) begin
                                rx_sr <= rx_in;
                            end
                            if (do_shift) begin
                                tx_sr <= tx_next;
                                mosi  <= mosi_next;
                            end
                            if (edge_nxt == 5'd16) begin
                                // With cpha=1 edge 16 carries the last sample,
                                // so take the freshly assembled byte.
                                state       <= ST_DONE;
                                ss          <= 1'b1;
                                tip_q       <= 1'b0;
                                rd_q        <= 1'b1;
                                miso_data_q <= do_sample ? rx_in : rx_sr;
                                sclk        <= cpol_q;
                                mosi        <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    ss    <= 1'b1;
                    tip_q <= 1'b0;
                    mosi  <= 1'b0;
                    sclk  <= bus.cpol;
                end

                default: begin
                    state <= ST_IDLE;
                    ss    <= 1'b1;
                    tip_q <= 1'b0;
                    mosi  <= 1'b0;
                    sclk  <= bus.cpol;
                end
            endcase
        end
    end

    assign bus.tip          = tip_q;
    assign bus.receive_data = rd_q;
    assign bus.miso_data    = miso_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_shift_engine
//
// Directed bench for spi_shift_engine: loopback, LSB first, baud timing,
// mode 3, stop mode, abort and mid-transfer reset.
// ---------------------------------------------------------------------------
module tb_spi_shift_engine;

    logic PCLK;
    logic PRESETn;
    logic miso;
    logic sclk;
    logic mosi;
    logic ss;
    logic loop_en;
    logic miso_tie;

    int n_checks;
    int n_errors;

    int         r_tip_cyc;
    int         r_edges;
    int         r_rise;
    int         r_rd;
    int         r_start_wait;
    int         r_edge1_idx;
    int         r_edge3_idx;
    int         r_first_edge_val;
    int         r_viol;
    int         r_ss_done;
    logic [7:0] r_seq;

    spi_shift_engine_if vif ();

    spi_shift_engine #(.CNT_W(11)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (vif),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss      (ss)
    );

    assign miso = loop_en ? mosi : miso_tie;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a transfer with the current configuration and follows it until
    // DONE, optionally entering stop mode for stop_len cycles after edge
    // stop_edge. Called right after a falling PCLK edge.
    task automatic run_xfer(input int stop_edge, input int stop_len);
        logic prev_sclk;
        logic prev_mosi;
        int   guard;
        int   stop_cnt;
        bit   stop_done;
        r_tip_cyc = 0; r_edges = 0; r_rise = 0; r_rd = 0; r_start_wait = 0;
        r_edge1_idx = -1; r_edge3_idx = -1; r_first_edge_val = -1; r_viol = 0;
        r_ss_done = 0; r_seq = 8'h00;
        guard = 0; stop_cnt = 0; stop_done = 0;
        prev_sclk = sclk;
        prev_mosi = mosi;
        vif.send_data = 1'b1;
        @(negedge PCLK);
        while (!vif.tip && guard < 50) begin
            r_start_wait++;
            guard++;
            @(negedge PCLK);
        end
        vif.send_data = 1'b0;
        guard = 0;
        while (guard < 5000) begin
            if (stop_cnt > 0) begin
                if (sclk !== prev_sclk || mosi !== prev_mosi) r_viol++;
                stop_cnt--;
                if (stop_cnt == 0) vif.spi_mode = 2'b00;
            end
            if (sclk !== prev_sclk) begin
                r_edges++;
                if (sclk) r_rise++;
                if (r_edges == 1) begin
                    r_edge1_idx = r_tip_cyc;
                    r_first_edge_val = int'(sclk);
                end
                if (r_edges == 3) r_edge3_idx = r_tip_cyc;
                if ((r_edges % 2) == (vif.cpha ? 0 : 1)) r_seq = {r_seq[6:0], prev_mosi};
                if (r_edges == stop_edge && !stop_done) begin
                    stop_done = 1;
                    stop_cnt = stop_len;
                    vif.spi_mode = 2'b10;
                end
            end
            r_rd += int'(vif.receive_data);
            if (!vif.tip) break;
            r_tip_cyc++;
            prev_sclk = sclk;
            prev_mosi = mosi;
            guard++;
            @(negedge PCLK);
        end
        check("xfer_timeout", guard < 5000, 1);
        r_ss_done = int'(ss);
        repeat (2) begin
            @(negedge PCLK);
            r_rd += int'(vif.receive_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        PRESETn = 1'b0;
        loop_en = 1'b1;
        miso_tie = 1'b0;
        vif.send_data = 1'b0;
        vif.mosi_data = 8'h00;
        vif.mstr = 1'b1;
        vif.cpol = 1'b0;
        vif.cpha = 1'b0;
        vif.lsbfe = 1'b0;
        vif.spi_mode = 2'b00;
        vif.sppr = 3'd0;
        vif.spr = 3'd0;
        repeat (3) @(negedge PCLK);

        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ss", ss, 1);
        check("rst_tip", vif.tip, 0);
        check("rst_rd", vif.receive_data, 0);
        check("rst_miso_data", vif.miso_data, 8'h00);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // Basic loopback, H=1, mode 0, MSB first.
        vif.mosi_data = 8'hA5;
        run_xfer(0, 0);
        check("t1_start_latency", r_start_wait, 0);
        check("t1_tip_cycles", r_tip_cyc, 16);
        check("t1_edges", r_edges, 16);
        check("t1_rises", r_rise, 8);
        check("t1_first_edge", r_edge1_idx, 1);
        check("t1_mosi_seq", r_seq, 8'hA5);
        check("t1_rd_pulses", r_rd, 1);
        check("t1_miso_data", vif.miso_data, 8'hA5);
        check("t1_ss_done", r_ss_done, 1);

        // LSB first, miso tied high.
        loop_en = 1'b0;
        miso_tie = 1'b1;
        vif.lsbfe = 1'b1;
        vif.mosi_data = 8'h01;
        run_xfer(0, 0);
        check("t2_mosi_seq", r_seq, 8'h80);
        check("t2_miso_data", vif.miso_data, 8'hFF);
        check("t2_rd_pulses", r_rd, 1);

        // Baud timing: sppr=2, spr=1 -> H=6.
        loop_en = 1'b1;
        vif.lsbfe = 1'b0;
        vif.sppr = 3'd2;
        vif.spr = 3'd1;
        vif.mosi_data = 8'h5A;
        run_xfer(0, 0);
        check("t3_tip_cycles", r_tip_cyc, 96);
        check("t3_first_edge", r_edge1_idx, 6);
        check("t3_sclk_period", r_edge3_idx - r_edge1_idx, 12);
        check("t3_miso_data", vif.miso_data, 8'h5A);

        // Mode 3 loopback.
        vif.sppr = 3'd0;
        vif.spr = 3'd0;
        vif.cpol = 1'b1;
        vif.cpha = 1'b1;
        vif.mosi_data = 8'h3C;
        repeat (2) @(negedge PCLK);
        check("t4_idle_sclk", sclk, 1);
        check("t4_ss_before", ss, 1);
        run_xfer(0, 0);
        check("t4_first_edge_val", r_first_edge_val, 0);
        check("t4_mosi_seq", r_seq, 8'h3C);
        check("t4_miso_data", vif.miso_data, 8'h3C);
        check("t4_ss_after", r_ss_done, 1);
        check("t4_ss_idle", ss, 1);
        check("t4_rd_pulses", r_rd, 1);

        // Stop mode for 20 cycles after edge 5.
        vif.cpol = 1'b0;
        vif.cpha = 1'b0;
        vif.mosi_data = 8'hC3;
        repeat (2) @(negedge PCLK);
        run_xfer(5, 20);
        check("t5_tip_cycles", r_tip_cyc, 36);
        check("t5_frozen", r_viol, 0);
        check("t5_edges", r_edges, 16);
        check("t5_miso_data", vif.miso_data, 8'hC3);

        // Abort mid-transfer.
        vif.mosi_data = 8'h77;
        vif.send_data = 1'b1;
        @(negedge PCLK);
        vif.send_data = 1'b0;
        check("t6_tip_started", vif.tip, 1);
        repeat (5) @(negedge PCLK);
        vif.mstr = 1'b0;
        @(negedge PCLK);
        check("t6_abort_ss", ss, 1);
        check("t6_abort_tip", vif.tip, 0);
        check("t6_abort_rd", vif.receive_data, 0);
        check("t6_abort_miso_data", vif.miso_data, 8'hC3);
        r_rd = 0;
        repeat (20) begin
            @(negedge PCLK);
            r_rd += int'(vif.receive_data);
        end
        check("t6_no_rd_after", r_rd, 0);
        vif.mstr = 1'b1;

        // Reset mid-transfer, then restart.
        vif.cpol = 1'b1;
        vif.sppr = 3'd3;
        vif.mosi_data = 8'hFF;
        repeat (2) @(negedge PCLK);
        vif.send_data = 1'b1;
        @(negedge PCLK);
        vif.send_data = 1'b0;
        check("t7_pre_sclk", sclk, 1);
        check("t7_pre_mosi", mosi, 1);
        check("t7_pre_ss", ss, 0);
        #2;
        PRESETn = 1'b0;
        #1;
        check("t7_rst_sclk", sclk, 0);
        check("t7_rst_mosi", mosi, 0);
        check("t7_rst_ss", ss, 1);
        check("t7_rst_tip", vif.tip, 0);
        check("t7_rst_rd", vif.receive_data, 0);
        check("t7_rst_miso_data", vif.miso_data, 8'h00);
        @(negedge PCLK);
        PRESETn = 1'b1;
        vif.cpol = 1'b0;
        vif.sppr = 3'd0;
        vif.mosi_data = 8'h96;
        repeat (2) @(negedge PCLK);
        run_xfer(0, 0);
        check("t7_restart_tip_cycles", r_tip_cyc, 16);
        check("t7_restart_miso_data", vif.miso_data, 8'h96);
        check("t7_restart_rd", r_rd, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
